score_keeper: RTL and testbench
===============================

// Module: score_keeper
// PURPOSE
//  Producer side of the scoreboard score bus: turns raw player push-buttons into two BCD scores
//  (p1/p2 tens+ones) that the display multiplexer reads. Runs on the 1 kHz system clock.
//  Debounces buttons, increments BCD scores, detects game end and holds scores until cleared.
// PARAMETERS
//  DEBOUNCE_MS  20  consecutive stable samples (1 ms each) required to accept a button level change
//  WIN_SCORE    21  score (decimal, legal range 1..99) that ends the game
// PORTS
//  clk_1khz     in   1  system clock, 1 kHz
//  rst_i        in   1  asynchronous, active-high reset
//  p1_btn_i     in   1  raw player-1 point button, active high, asynchronous to clk
//  p2_btn_i     in   1  raw player-2 point button, active high, asynchronous to clk
//  clear_i      in   1  raw new-game button, active high, debounced like the point buttons
//  undo_btn_i   in   1  raw undo button (present only with SCORE_UNDO_EN)
//  p1_tens_o    out  4  player-1 BCD tens digit, 0..9
//  p1_ones_o    out  4  player-1 BCD ones digit, 0..9
//  p2_tens_o    out  4  player-2 BCD tens digit
//  p2_ones_o    out  4  player-2 BCD ones digit
//  winner_o     out  2  00 none, 01 P1, 10 P2, 11 draw
//  game_over_o  out  1  high in state OVER
// BEHAVIOUR
//  - Reset (async assert, sync deassert by clock edge): all digits 0, winner_o=00, game_over_o=0,
//    state PLAY, debouncers report stable-low, undo history empty.
//  - Debounce per button: 2-FF synchroniser; counter counts cycles where synced != accepted level,
//    cleared whenever they agree; at DEBOUNCE_MS mismatching cycles the accepted level flips.
//    A 0->1 flip of the accepted level emits a one-cycle pulse. Release does not pulse.
//  - Latency: raw press held steady -> score output changes DEBOUNCE_MS+3 clock edges after the
//    raw rising edge. A glitch shorter than DEBOUNCE_MS cycles never changes a score.
//  - Holding a button yields exactly one point; a new point needs release (accepted) + press.
//  - Increment: BCD. ones 9 -> 0 with tens+1. Scores never exceed WIN_SCORE, so no 99 wrap.
//  - FSM:
//    PLAY: p1/p2 pulses increment the respective score. Both pulses in one cycle: both increment.
//          After an update, if exactly one score == WIN_SCORE -> OVER with winner set.
//          If both == WIN_SCORE -> OVER, winner_o=11. winner_o and game_over_o are registered
//          and change on the same edge as the winning digit.
//    OVER: point pulses ignored. Scores and winner held.
//    Any state: clear pulse -> PLAY, all digits 0, winner 00, undo history empty, next edge.
//          Clear has priority over point/undo pulses in the same cycle.
//  - Reset mid-debounce discards partial counts. A held button after reset needs full
//    DEBOUNCE_MS to register (accepted level starts low).
// CONFIGURATION
//  SCORE_UNDO_EN defined: undo_btn_i port exists. Last-scorer register (none/P1/P2/both) records
//    the most recent increment. An undo pulse BCD-decrements that player(s): 0 tens with ones 0
//    never goes below 00. It clears the history (single level) and, from OVER, returns to PLAY
//    with winner 00. Undo with empty history is a no-op. Point pulse in the same cycle as undo:
//    the undo applies, the point is dropped.
//  SCORE_UNDO_EN undefined: no undo port, no history register. Scores are monotonic until clear.
// STRUCTURE
//  - scoreboard_pkg (shared include): FSM state encodings ST_PLAY/ST_OVER, winner codes
//    WIN_NONE/WIN_P1/WIN_P2/WIN_DRAW, BCD helper functions bcd_inc/bcd_dec. The display path
//    reuses these.
//  - Sub-module btn_debounce (param DEBOUNCE_MS): synchroniser, filter counter, rise-pulse.
//    Instantiated once per button (3, or 4 with undo).
//  - score_keeper top: BCD score registers, FSM, optional undo history.
// TESTING
//  1. Reset, then P1 press held 30 ms -> p1 = 0/1 exactly at edge DEBOUNCE_MS+3 after the press.
//     Holding 200 ms more gives no further change.
//  2. 5 ms P2 glitch, then 10 ms low, repeated -> p2 stays 0/0.
//  3. Eleven P1 points from 08 -> carry 09->10, final p1_tens=1, p1_ones=9, no stray digits >9.
//  4. Both at 20, both buttons pressed in the same cycle -> both 2/1, winner_o=11, game_over_o=1.
//     A further P1 press changes nothing.
//  5. In OVER, clear press -> next edge after its pulse: all digits 0, winner 00, game_over_o=0.
//  6. SCORE_UNDO_EN: P2 scores the winning 21, then undo -> p2=2/0, PLAY, winner 00.
//     A second undo is a no-op. rst_i pulsed mid-press -> outputs 0 immediately, async.

Source files
------------

// File: rtl/scoreboard_pkg.sv
// Shared scoreboard types and BCD helpers, used by score_keeper and the display path.
package scoreboard_pkg;

  typedef enum logic {
    ST_PLAY = 1'b0,
    ST_OVER = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_e;

  typedef enum logic [1:0] {
    LAST_NONE = 2'b00,
    LAST_P1   = 2'b01,
    LAST_P2   = 2'b10,
    LAST_BOTH = 2'b11
  } last_e;

  // Two-digit BCD value {tens, ones}; 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd9) return 8'h00;
      return {v[7:4] + 4'd1, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Saturates at 00.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v == 8'h00) return 8'h00;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic [7:0] to_bcd(input int unsigned n);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'((n / 10) % 10);
    o = 4'(n % 10);
    return {t, o};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability filter and press (rise) pulse.
module btn_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic rise_o
);

  localparam int CW = (DEBOUNCE_MS < 2) ? 1 : $clog2(DEBOUNCE_MS);

  logic          sync1_q, sync2_q;
  logic          level_q;
  logic          rise_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      if (sync2_q != level_q) begin
        // The DEBOUNCE_MS-th consecutive mismatching cycle flips the accepted level.
        if (cnt_q == CW'(DEBOUNCE_MS - 1)) begin
          level_q <= sync2_q;
          rise_q  <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/score_keeper.sv
// Two-player BCD score keeper with game-over detection.
// Optional undo of the most recent point when SCORE_UNDO_EN is defined.
module score_keeper
  import scoreboard_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int WIN_SCORE   = 21
) (
  input  logic       clk_1khz,
  input  logic       rst_i,
  input  logic       p1_btn_i,
  input  logic       p2_btn_i,
  input  logic       clear_i,
`ifdef SCORE_UNDO_EN
  input  logic       undo_btn_i,
`endif
  output logic [3:0] p1_tens_o,
  output logic [3:0] p1_ones_o,
  output logic [3:0] p2_tens_o,
  output logic [3:0] p2_ones_o,
  output logic [1:0] winner_o,
  output logic       game_over_o
);

  localparam logic [7:0] WIN_BCD = to_bcd(WIN_SCORE);

  logic p1_p, p2_p, clear_p;

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_p1 (
    .clk_i(clk_1khz), .rst_i(rst_i), .btn_i(p1_btn_i), .rise_o(p1_p));
  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_p2 (
    .clk_i(clk_1khz), .rst_i(rst_i), .btn_i(p2_btn_i), .rise_o(p2_p));
  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_clr (
    .clk_i(clk_1khz), .rst_i(rst_i), .btn_i(clear_i), .rise_o(clear_p));

  logic [7:0] p1_q, p1_d, p2_q, p2_d;
  state_e     state_q, state_d;
  winner_e    winner_q, winner_d;

`ifdef SCORE_UNDO_EN
  logic  undo_p;
  last_e last_q, last_d;

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_undo (
    .clk_i(clk_1khz), .rst_i(rst_i), .btn_i(undo_btn_i), .rise_o(undo_p));
`endif

  always_comb begin
    p1_d     = p1_q;
    p2_d     = p2_q;
    state_d  = state_q;
    winner_d = winner_q;
`ifdef SCORE_UNDO_EN
    last_d   = last_q;
`endif
    if (clear_p) begin
      p1_d     = 8'h00;
      p2_d     = 8'h00;
      state_d  = ST_PLAY;
      winner_d = WIN_NONE;
`ifdef SCORE_UNDO_EN
      last_d   = LAST_NONE;
`endif
    end
`ifdef SCORE_UNDO_EN
    // An undo pulse always swallows a simultaneous point pulse.
    else if (undo_p) begin
      if (last_q != LAST_NONE) begin
        if (last_q == LAST_P1 || last_q == LAST_BOTH) p1_d = bcd_dec(p1_q);
        if (last_q == LAST_P2 || last_q == LAST_BOTH) p2_d = bcd_dec(p2_q);
        state_d  = ST_PLAY;
        winner_d = WIN_NONE;
        last_d   = LAST_NONE;
      end
    end
`endif
    else if (state_q == ST_PLAY && (p1_p || p2_p)) begin
      if (p1_p) p1_d = bcd_inc(p1_q);
      if (p2_p) p2_d = bcd_inc(p2_q);
`ifdef SCORE_UNDO_EN
      last_d = last_e'({p2_p, p1_p});
`endif
      if (p1_d == WIN_BCD && p2_d == WIN_BCD) begin
        state_d  = ST_OVER;
        winner_d = WIN_DRAW;
      end else if (p1_d == WIN_BCD) begin
        state_d  = ST_OVER;
        winner_d = WIN_P1;
      end else if (p2_d == WIN_BCD) begin
        state_d  = ST_OVER;
        winner_d = WIN_P2;
      end
    end
  end

  always_ff @(posedge clk_1khz or posedge rst_i) begin
    if (rst_i) begin
      p1_q     <= 8'h00;
      p2_q     <= 8'h00;
      state_q  <= ST_PLAY;
      winner_q <= WIN_NONE;
`ifdef SCORE_UNDO_EN
      last_q   <= LAST_NONE;
`endif
    end else begin
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      state_q  <= state_d;
      winner_q <= winner_d;
`ifdef SCORE_UNDO_EN
      last_q   <= last_d;
`endif
    end
  end

  assign p1_tens_o   = p1_q[7:4];
  assign p1_ones_o   = p1_q[3:0];
  assign p2_tens_o   = p2_q[7:4];
  assign p2_ones_o   = p2_q[3:0];
  assign winner_o    = winner_q;
  assign game_over_o = (state_q == ST_OVER);

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: integer score model checked every cycle,
// plus literal spot checks. Undo scenarios are built when SCORE_UNDO_EN is defined.
module tb_score_keeper;

  localparam int D = 20;
  localparam int W = 21;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       p1 = 1'b0, p2 = 1'b0, clr = 1'b0;
`ifdef SCORE_UNDO_EN
  logic       und = 1'b0;
`endif
  logic [3:0] p1_tens, p1_ones, p2_tens, p2_ones;
  logic [1:0] winner;
  logic       over;

  score_keeper #(.DEBOUNCE_MS(D), .WIN_SCORE(W)) dut (
    .clk_1khz(clk), .rst_i(rst),
    .p1_btn_i(p1), .p2_btn_i(p2), .clear_i(clr),
`ifdef SCORE_UNDO_EN
    .undo_btn_i(und),
`endif
    .p1_tens_o(p1_tens), .p1_ones_o(p1_ones),
    .p2_tens_o(p2_tens), .p2_ones_o(p2_ones),
    .winner_o(winner), .game_over_o(over));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: plain integer scores following the game rules.
  int m_p1 = 0, m_p2 = 0, m_win = 0, m_last = 0;
  bit m_over = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_p1 = 0; m_p2 = 0; m_win = 0; m_last = 0; m_over = 0;
  endfunction

  function automatic void m_point(input bit a, input bit b);
    if (m_over) return;
    if (a) m_p1++;
    if (b) m_p2++;
    m_last = (a ? 1 : 0) + (b ? 2 : 0);
    if (m_p1 == W && m_p2 == W) begin m_over = 1; m_win = 3; end
    else if (m_p1 == W) begin m_over = 1; m_win = 1; end
    else if (m_p2 == W) begin m_over = 1; m_win = 2; end
  endfunction

  function automatic void m_undo();
    if (m_last == 0) return;
    if ((m_last & 1) != 0 && m_p1 > 0) m_p1--;
    if ((m_last & 2) != 0 && m_p2 > 0) m_p2--;
    m_last = 0; m_over = 0; m_win = 0;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("p1_tens", int'(p1_tens), m_p1 / 10);
    check("p1_ones", int'(p1_ones), m_p1 % 10);
    check("p2_tens", int'(p2_tens), m_p2 / 10);
    check("p2_ones", int'(p2_ones), m_p2 % 10);
    check("winner", int'(winner), m_win);
    check("game_over", int'(over), int'(m_over));
    check("digits_legal", int'(p1_tens <= 9 && p1_ones <= 9 && p2_tens <= 9 && p2_ones <= 9), 1);
  end

  // Press for one debounced event; the model updates on the edge the outputs must change.
  task automatic press(input bit a, input bit b, input bit c, input bit u, input int hold);
    @(negedge clk);
    p1 = a; p2 = b; clr = c;
`ifdef SCORE_UNDO_EN
    und = u;
`endif
    repeat (D + 3) @(posedge clk);
    #1;
    if (c) m_reset();
    else if (u) m_undo();
    else m_point(a, b);
    repeat (hold) @(negedge clk);
    p1 = 0; p2 = 0; clr = 0;
`ifdef SCORE_UNDO_EN
    und = 0;
`endif
    repeat (D + 6) @(negedge clk);
  endtask

  initial begin
    m_reset();
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    check("reset_p1", int'({p1_tens, p1_ones}), 0);
    check("reset_winner", int'(winner), 0);

    // 1: exact latency, then a long hold gives one point only.
    @(negedge clk);
    p1 = 1;
    repeat (D + 2) @(posedge clk);
    #1 check("lat_before", int'(p1_ones), 0);
    @(posedge clk);
    #1 m_point(1, 0);
    check("lat_at", int'(p1_ones), 1);
    repeat (208) @(negedge clk);
    check("hold_one_point", int'(p1_ones), 1);
    p1 = 0;
    repeat (D + 6) @(negedge clk);

    // 2: short glitches on P2 never count.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); p2 = 1;
      repeat (5) @(negedge clk); p2 = 0;
      repeat (10) @(negedge clk);
    end
    repeat (D + 6) @(negedge clk);
    check("glitch_p2", int'({p2_tens, p2_ones}), 0);

    // 3: to 08, then eleven points through the 09->10 carry.
    for (int i = 0; i < 7; i++) press(1, 0, 0, 0, 2);
    check("p1_is_08", int'({p1_tens, p1_ones}), 8'h08);
    for (int i = 0; i < 11; i++) press(1, 0, 0, 0, 2);
    check("p1_tens_19", int'(p1_tens), 1);
    check("p1_ones_19", int'(p1_ones), 9);

    // 4: both at 20, simultaneous press -> draw; later presses ignored.
    press(1, 0, 0, 0, 2);
    for (int i = 0; i < 20; i++) press(0, 1, 0, 0, 2);
    check("p2_is_20", int'({p2_tens, p2_ones}), 8'h20);
    check("not_over_20", int'(over), 0);
    press(1, 1, 0, 0, 2);
    check("draw_p1", int'({p1_tens, p1_ones}), 8'h21);
    check("draw_p2", int'({p2_tens, p2_ones}), 8'h21);
    check("draw_winner", int'(winner), 3);
    check("draw_over", int'(over), 1);
    press(1, 0, 0, 0, 2);
    check("over_ignores", int'({p1_tens, p1_ones}), 8'h21);

    // 5: clear from OVER.
    press(0, 0, 1, 0, 2);
    check("clear_p1", int'({p1_tens, p1_ones}), 0);
    check("clear_winner", int'(winner), 0);
    check("clear_over", int'(over), 0);

`ifdef SCORE_UNDO_EN
    // 6: P2 wins, undo returns to PLAY at 20; second undo is a no-op.
    for (int i = 0; i < 21; i++) press(0, 1, 0, 0, 2);
    check("p2_wins", int'(winner), 2);
    press(0, 0, 0, 1, 2);
    check("undo_p2", int'({p2_tens, p2_ones}), 8'h20);
    check("undo_winner", int'(winner), 0);
    check("undo_over", int'(over), 0);
    press(0, 0, 0, 1, 2);
    check("undo_noop", int'({p2_tens, p2_ones}), 8'h20);
    press(0, 0, 1, 0, 2);
`endif

    // Async reset mid-press, then a held button needs the full debounce again.
    press(1, 0, 0, 0, 2);
    press(1, 0, 0, 0, 2);
    check("pre_rst_p1", int'({p1_tens, p1_ones}), 2);
    @(negedge clk);
    p1 = 1;
    repeat (10) @(negedge clk);
    #2 rst = 1;
    m_reset();
    #1 check("async_rst_p1", int'({p1_tens, p1_ones}), 0);
    @(negedge clk);
    rst = 0;
    repeat (D + 2) @(posedge clk);
    #1 check("post_rst_before", int'(p1_ones), 0);
    @(posedge clk);
    #1 m_point(1, 0);
    check("post_rst_at", int'(p1_ones), 1);
    repeat (5) @(negedge clk);
    p1 = 0;
    repeat (D + 6) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
